// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus request/response types and arbiter FSM encoding.
// Imported by dbus_arbiter and dbus_arbiter_rr_picker.
package dbus_arbiter_pkg;

    localparam int DBUS_NREQ = 2;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Response handed to a requester on its completion cycle.
    function automatic dbus_resp_t make_done_resp(input logic [63:0] bus_data);
        dbus_resp_t r;
        r         = '0;
        r.addr_ok = 1'b1;
        r.data_ok = 1'b1;
        r.data    = bus_data;
        return r;
    endfunction

endpackage

// File: rtl/dbus_arbiter_rr_picker.sv
// Combinational rotating picker: first set request strictly after 'last', wrapping.
// With last tied to NREQ-1 it degenerates to lowest-index-wins.
module dbus_arbiter_rr_picker
    import dbus_arbiter_pkg::*;
#(
    parameter int NREQ = DBUS_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant,
    output logic                    found
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] idx_s;
    logic             hit_s;

    // Walk the candidates in rotation order and grant the first requester seen.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx_s = '0;
        hit_s = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            idx_s        = IDX_W'((int'(last) + off) % NREQ);
            hit_s        = req[idx_s] & ~found;
            grant[idx_s] = hit_s;
            found        = found | hit_s;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter: grants one requester at a time, holds its request until data_ok.
// Define DBUS_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest); default is round-robin.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int NREQ = DBUS_NREQ
) (
    input  logic                    clk,
    input  logic                    reset,
    input  dbus_req_t               creq  [NREQ],
    output dbus_resp_t              cresp [NREQ],
    output dbus_req_t               dreq,
    input  dbus_resp_t              dresp,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    dbus_req_t        req_q;
    dbus_req_t        req_d;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] owner_d;

    logic [NREQ-1:0]  valid_vec_s;
    logic [NREQ-1:0]  grant_s;
    logic             found_s;
    logic [IDX_W-1:0] pick_last_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             take_s;
    logic             done_s;

`ifdef DBUS_ARB_FIXED_PRIO_EN
    assign pick_last_s = LAST_IDX;
`else
    logic [IDX_W-1:0] rr_last_q;
    logic [IDX_W-1:0] rr_last_d;

    assign pick_last_s = rr_last_q;
`endif

    // Gather the per-port valid bits for the picker.
    always_comb begin
        valid_vec_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            valid_vec_s[i] = creq[i].valid;
        end
    end

    dbus_arbiter_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req   (valid_vec_s),
        .last  (pick_last_s),
        .grant (grant_s),
        .found (found_s)
    );

    // Encode the one-hot grant into a port index.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_idx_s = win_idx_s | (grant_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

    assign take_s = (state_q == ARB_IDLE) && found_s;
    assign done_s = (state_q == ARB_BUSY) && dresp.data_ok;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a completion always returns to IDLE, giving one bubble cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (found_s) begin
                    state_d = ARB_BUSY;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (dresp.data_ok) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_BUSY;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant-time capture of the winning request, owner and rotation pointer.
    always_comb begin
        req_d   = req_q;
        owner_d = owner_q;
`ifndef DBUS_ARB_FIXED_PRIO_EN
        rr_last_d = rr_last_q;
`endif
        if (take_s) begin
            req_d   = creq[win_idx_s];
            owner_d = win_idx_s;
`ifndef DBUS_ARB_FIXED_PRIO_EN
            rr_last_d = win_idx_s;
`endif
        end else begin
            req_d   = req_q;
            owner_d = owner_q;
        end
    end

    // Datapath registers; live requester changes cannot reach the bus once latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            owner_q <= '0;
`ifndef DBUS_ARB_FIXED_PRIO_EN
            rr_last_q <= LAST_IDX;
`endif
        end else begin
            req_q   <= req_d;
            owner_q <= owner_d;
`ifndef DBUS_ARB_FIXED_PRIO_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    // Bus-side outputs: the latched request is presented only while BUSY.
    always_comb begin
        dreq = '0;
        case (state_q)
            ARB_BUSY: begin
                dreq       = req_q;
                dreq.valid = 1'b1;
            end
            ARB_IDLE: dreq = '0;
            default:  dreq = '0;
        endcase
    end

    // Requester-side outputs: only a still-valid owner sees its completion.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cresp[i] = '0;
            if (done_s && (owner_q == IDX_W'(i)) && creq[i].valid) begin
                cresp[i] = make_done_resp(dresp.data);
            end else begin
                cresp[i] = '0;
            end
        end
    end

    assign busy  = (state_q == ARB_BUSY);
    assign owner = owner_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    localparam int NREQ = 2;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  creq  [NREQ];
    dbus_resp_t cresp [NREQ];
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       busy;
    logic [0:0] owner;

    int checks   = 0;
    int failures = 0;

    // reference model: one outstanding transaction record plus rotation pointer
    bit        m_busy  = 1'b0;
    int        m_owner = 0;
    int        m_last  = NREQ - 1;
    dbus_req_t m_req   = '0;

    bit prev_dv = 1'b0;
    int obs_grants[$];
    int ok_cnt[NREQ];
    int exp_g[5];

    dbus_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp),
        .dreq  (dreq),
        .dresp (dresp),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        dbus_req_t  e_req;
        dbus_resp_t e_resp;
        e_req = '0;
        if (m_busy) begin
            e_req       = m_req;
            e_req.valid = 1'b1;
        end
        chk("dreq", 160'(dreq), 160'(e_req));
        chk("busy", 160'(busy), 160'(m_busy));
        chk("owner", 160'(owner), 160'(m_owner));
        for (int i = 0; i < NREQ; i++) begin
            e_resp = '0;
            if (m_busy && dresp.data_ok && i == m_owner && creq[i].valid) begin
                e_resp.addr_ok = 1'b1;
                e_resp.data_ok = 1'b1;
                e_resp.data    = dresp.data;
            end
            chk($sformatf("cresp%0d", i), 160'(cresp[i]), 160'(e_resp));
            ok_cnt[i] += int'(cresp[i].data_ok);
        end
        if (dreq.valid && !prev_dv) obs_grants.push_back(int'(owner));
        prev_dv = dreq.valid;
    endtask

    task automatic model_update();
        int w;
        int cand;
        w = -1;
        if (reset) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = NREQ - 1;
        end else if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
`ifdef DBUS_ARB_FIXED_PRIO_EN
                cand = k;
`else
                cand = (m_last + 1 + k) % NREQ;
`endif
                if (w < 0 && creq[cand].valid) w = cand;
            end
            if (w >= 0) begin
                m_req   = creq[w];
                m_owner = w;
                m_last  = w;
                m_busy  = 1'b1;
            end
        end else if (dresp.data_ok) begin
            m_busy = 1'b0;
        end
    endtask

    // one clock: check outputs mid-cycle, advance model at the edge, return at negedge
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_ok(input bit ok, input logic [63:0] d);
        dresp         = '0;
        dresp.data_ok = ok;
        dresp.addr_ok = ok;
        dresp.data    = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] addr_a;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) creq[i] = '0;
        dresp = '0;
`ifdef DBUS_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 1};
`else
        exp_g = '{0, 1, 0, 1, 1};
`endif
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc();
        reset = 1'b0;
        cyc();

        // single port-1 load, data_ok after 3 busy cycles
        ok_cnt = '{0, 0};
        creq[1] = '{valid: 1'b1, addr: 64'h0000_0000_8000_0010, size: MSIZE8,
                    strobe: 8'hFF, data: 64'h0};
        cyc();
        cyc();
        cyc();
        set_ok(1'b1, 64'h0000_0000_DEAD_BEEF);
        cyc();
        set_ok(1'b0, 64'h0);
        creq[1].valid = 1'b0;
        cyc();
        cyc();
        chk("load_ok_cnt1", 160'(ok_cnt[1]), 160'(1));
        chk("load_ok_cnt0", 160'(ok_cnt[0]), 160'(0));

        // both ports held valid from reset: grant order
        do_reset();
        obs_grants.delete();
        creq[0] = '{valid: 1'b1, addr: 64'h1000, size: MSIZE8, strobe: 8'hFF, data: 64'h0};
        creq[1] = '{valid: 1'b1, addr: 64'h2000, size: MSIZE4, strobe: 8'h0F, data: 64'h0};
        for (int t = 0; t < 5; t++) begin
            if (t == 4) creq[0].valid = 1'b0;
            cyc();
            cyc();
            set_ok(1'b1, 64'(t + 100));
            cyc();
            set_ok(1'b0, 64'h0);
        end
        creq[1].valid = 1'b0;
        cyc();
        chk("grant_count", 160'(obs_grants.size()), 160'(5));
        for (int t = 0; t < 5 && t < obs_grants.size(); t++) begin
            chk($sformatf("grant_order%0d", t), 160'(obs_grants[t]), 160'(exp_g[t]));
        end

        // port-1 store; live fields change while BUSY
        addr_a  = 64'h0000_0000_4000_0008;
        creq[1] = '{valid: 1'b1, addr: addr_a, size: MSIZE8, strobe: 8'hF0,
                    data: 64'h1234_5678_0000_0000};
        cyc();
        creq[1].addr   = 64'h0000_0000_5555_0000;
        creq[1].strobe = 8'h0F;
        creq[1].data   = 64'h0BAD_0BAD_0BAD_0BAD;
        cyc();
        cyc();
        chk("store_addr_held", 160'(dreq.addr), 160'(addr_a));
        chk("store_strb_held", 160'(dreq.strobe), 160'(8'hF0));
        set_ok(1'b1, 64'h0);
        cyc();
        set_ok(1'b0, 64'h0);
        creq[1].valid = 1'b0;
        cyc();

        // port 0 drops valid after grant; response discarded, port 1 next
        ok_cnt  = '{0, 0};
        obs_grants.delete();
        creq[0] = '{valid: 1'b1, addr: 64'h3000, size: MSIZE8, strobe: 8'hFF, data: 64'h0};
        creq[1] = '{valid: 1'b1, addr: 64'h3100, size: MSIZE8, strobe: 8'hFF, data: 64'h0};
        cyc();
        cyc();
        creq[0].valid = 1'b0;
        cyc();
        set_ok(1'b1, 64'h77);
        cyc();
        set_ok(1'b0, 64'h0);
        cyc();
        cyc();
        set_ok(1'b1, 64'h88);
        cyc();
        set_ok(1'b0, 64'h0);
        creq[1].valid = 1'b0;
        cyc();
        chk("drop_ok_cnt0", 160'(ok_cnt[0]), 160'(0));
        chk("drop_ok_cnt1", 160'(ok_cnt[1]), 160'(1));
        chk("drop_next_grant", 160'((obs_grants.size() == 2) ? obs_grants[1] : -1), 160'(1));

        // reset while BUSY, then a normal port-1 request
        creq[0] = '{valid: 1'b1, addr: 64'h6000, size: MSIZE2, strobe: 8'h03, data: 64'h0};
        cyc();
        cyc();
        reset = 1'b1;
        creq[0].valid = 1'b0;
        cyc();
        reset = 1'b0;
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_owner", 160'(owner), 160'(0));
        chk("rst_dvalid", 160'(dreq.valid), 160'(0));
        ok_cnt  = '{0, 0};
        creq[1] = '{valid: 1'b1, addr: 64'h7000, size: MSIZE8, strobe: 8'hFF, data: 64'h0};
        cyc();
        set_ok(1'b1, 64'h99);
        cyc();
        set_ok(1'b0, 64'h0);
        creq[1].valid = 1'b0;
        cyc();
        chk("post_rst_ok_cnt1", 160'(ok_cnt[1]), 160'(1));

        // random traffic, including spurious data_ok and occasional reset
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (creq[i].valid) begin
                    if ($urandom_range(9) == 0) creq[i].valid = 1'b0;
                end else begin
                    creq[i].valid = ($urandom_range(2) == 0);
                end
                if ($urandom_range(3) == 0) begin
                    creq[i].addr   = {$urandom, $urandom};
                    creq[i].data   = {$urandom, $urandom};
                    creq[i].strobe = 8'($urandom);
                    creq[i].size   = msize_t'($urandom_range(3));
                end
            end
            set_ok($urandom_range(2) == 0, {$urandom, $urandom});
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data bus (dbus_req_t/dbus_resp_t) between NREQ requesters, e.g. port 0 = page-table walker, port 1 = memory-stage load/store.
- Sits between the pipeline/MMU requesters and the dbus toplevel port.
- Grants one requester at a time and registers its request so the bus sees a stable request until data_ok.
- Routes the response back only to the owner.

Parameters:
- NREQ, 2, number of requester ports (2..4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- creq  in  NREQ x dbus_req_t  per-requester request (valid, addr, size, strobe, data)
- cresp  out  NREQ x dbus_resp_t  per-requester response (addr_ok, data_ok, data)
- dreq  out  dbus_req_t  request to the data bus
- dresp  in  dbus_resp_t  response from the data bus
- busy  out  1  transaction outstanding (state BUSY)
- owner  out  $clog2(NREQ)  index of the current or last granted requester

Behaviour:
- Reset values:
  - state=IDLE, dreq all zero, every cresp all zero, busy=0, owner=0.
  - rr_last=NREQ-1, so port 0 wins first under round-robin.
- FSM states: IDLE, BUSY.
- IDLE:
  - Pick a winner among ports with creq[i].valid: the first valid index after rr_last, wrapping modulo NREQ.
  - If a winner exists: latch creq[win] fields into req_q, owner<=win, rr_last<=win, go to BUSY.
  - If no port is valid: stay in IDLE.
  - dreq.valid=0 in IDLE, so latency from request to dreq.valid is 1 cycle.
- BUSY:
  - dreq is driven from req_q with valid=1; fields are held constant until data_ok.
  - Live creq changes from the owner are ignored until completion.
- Completion cycle (dresp.data_ok=1 in BUSY):
  - cresp[owner].data_ok=1, cresp[owner].addr_ok=1 and cresp[owner].data=dresp.data, combinationally in the same cycle.
  - These are gated by creq[owner].valid: if the owner dropped valid mid-transaction, the response is silently discarded.
  - Next state is IDLE, leaving one bubble cycle between transactions.
- Non-owners always see cresp all zero.
- dresp.addr_ok is not forwarded separately; requesters rely on data_ok only.
- Simultaneous valid on all ports: round-robin guarantees each port is served within NREQ transactions.
- The owner re-requests immediately after its completion: it competes normally in IDLE and loses to any other valid port under round-robin.
- data_ok in IDLE (spurious): ignored; no cresp is asserted.
- No flush input. An in-flight bus transaction is never aborted; pipeline flushes act on the requester side by dropping valid.
- Reset asserted mid-BUSY returns to IDLE next cycle with dreq.valid=0. The bus environment is reset concurrently.
- strobe and data are passed through unmodified: alignment shifting stays in the requester.

Optional Feature:
- Macro DBUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (the page walker at port 0 always pre-empts at grant time). rr_last is not maintained and owner still updates.
- Undefined: round-robin as described above.
- In-flight transactions are never pre-empted in either mode.

Decomposition:
- In pipes package: arb_state_t enum {ARB_IDLE, ARB_BUSY} and constant DBUS_NREQ=2.
- dbus_req_t/dbus_resp_t stay in common.
- One sub-module, rr_picker: NREQ request vector plus last index gives a one-hot grant and a found flag. It is purely combinational and also used by the fixed-priority build with last forced to NREQ-1.

Test Plan:
- Single port 1 load, addr=0x8000_0010, size=MSIZE8, bus data_ok after 3 cycles with data=0xDEAD_BEEF -> dreq.valid rises the cycle after creq valid; cresp[1].data_ok=1 with data=0xDEAD_BEEF exactly once; cresp[0] stays zero.
- Ports 0 and 1 valid together from reset, held valid continuously, round-robin build -> grants in order 0,1,0,1; 1 idle cycle between each data_ok and the next dreq.valid.
- Same stimulus with DBUS_ARB_FIXED_PRIO_EN -> port 0 granted every time while valid; port 1 granted only once port 0 deasserts.
- Port 1 store, strobe=8'hF0, data=0x1234_5678_0000_0000; port 1 changes addr mid-BUSY -> dreq.addr, strobe and data remain the latched values until data_ok.
- Port 0 drops valid 1 cycle after grant; bus returns data_ok 2 cycles later -> dreq.valid held until data_ok; cresp[0].data_ok never asserted; arbiter returns to IDLE and serves port 1 next.
- Reset asserted while BUSY -> next cycle dreq.valid=0, busy=0, owner=0; a subsequent request from port 1 completes normally.
